// File: rtl/mio_bus_arbiter.sv
// Two-master memory/IO bus arbiter: CPU (master 0) has fixed priority, master 1 gets a starvation guard.
// Optional slave-acknowledge timeout is compiled in with `define MIO_TIMEOUT_EN.
module mio_bus_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_STREAK     = 4,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ready,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dev_req,
  input  logic          dev_we,
  input  logic [AW-1:0] dev_addr,
  input  logic [DW-1:0] dev_wdata,
  output logic          dev_ready,
  output logic [DW-1:0] dev_rdata,
  output logic          mem_req,
  output logic          mem_w,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          owner,
  output logic          bus_err
);

  if (MAX_STREAK < 1 || MAX_STREAK > 15 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("mio_bus_arbiter: MAX_STREAK must be 1..15 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_w_q, mem_w_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          cpu_ready_q, cpu_ready_d;
  logic          dev_ready_q, dev_ready_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dev_rdata_q, dev_rdata_d;
  logic [3:0]    streak_q, streak_d;
  logic          grant_dev;
  logic          done;
  logic [DW-1:0] done_data;
  logic          tmo_hit;

`ifdef MIO_TIMEOUT_EN
  localparam int          TW       = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic          bus_err_q, bus_err_d;

  // Counter restarts at every grant; the last BUSY cycle without an ack is the timeout.
  always_comb begin
    tmo_hit   = (state_q == BUSY) && !mem_ack && (tmo_cnt_q == TMO_LAST);
    tmo_cnt_d = (state_q == BUSY) ? tmo_cnt_q + TW'(1) : '0;
    bus_err_d = bus_err_q | tmo_hit;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tmo_cnt_q <= '0;
      bus_err_q <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    mem_req_d   = mem_req_q;
    mem_w_d     = mem_w_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    cpu_ready_d = 1'b0;
    dev_ready_d = 1'b0;
    cpu_rdata_d = cpu_rdata_q;
    dev_rdata_d = dev_rdata_q;
    streak_d    = streak_q;
    grant_dev   = 1'b0;
    done        = 1'b0;
    done_data   = mem_rdata;

    case (state_q)
      IDLE: begin
        if (cpu_req || dev_req) begin
          grant_dev   = dev_req && (!cpu_req || streak_q == STREAK_MAX);
          owner_d     = grant_dev;
          mem_req_d   = 1'b1;
          mem_w_d     = grant_dev ? dev_we    : cpu_we;
          mem_addr_d  = grant_dev ? dev_addr  : cpu_addr;
          mem_wdata_d = grant_dev ? dev_wdata : cpu_wdata;
          state_d     = BUSY;
          // Only a CPU win over a waiting master 1 counts toward the streak.
          if (grant_dev) begin
            streak_d = '0;
          end else if (dev_req && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
        end
      end
      BUSY: begin
        if (mem_ack) begin
          done = 1'b1;
        end else if (tmo_hit) begin
          done      = 1'b1;
          done_data = DW'(32'hDEAD_BEEF);
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (done) begin
      mem_req_d = 1'b0;
      mem_w_d   = 1'b0;
      state_d   = RESP;
      if (owner_q) begin
        dev_ready_d = 1'b1;
        dev_rdata_d = done_data;
      end else begin
        cpu_ready_d = 1'b1;
        cpu_rdata_d = done_data;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_w_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_ready_q <= 1'b0;
      dev_ready_q <= 1'b0;
      cpu_rdata_q <= '0;
      dev_rdata_q <= '0;
      streak_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      mem_req_q   <= mem_req_d;
      mem_w_q     <= mem_w_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_ready_q <= cpu_ready_d;
      dev_ready_q <= dev_ready_d;
      cpu_rdata_q <= cpu_rdata_d;
      dev_rdata_q <= dev_rdata_d;
      streak_q    <= streak_d;
    end
  end

  assign owner     = owner_q;
  assign mem_req   = mem_req_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_ready = cpu_ready_q;
  assign dev_ready = dev_ready_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dev_rdata = dev_rdata_q;

endmodule

// File: tb/tb_mio_bus_arbiter.sv
// Directed testbench for mio_bus_arbiter; timeout steps are included when MIO_TIMEOUT_EN is defined.
module tb_mio_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, dev_req, dev_we, mem_ack;
  logic [AW-1:0] cpu_addr, dev_addr;
  logic [DW-1:0] cpu_wdata, dev_wdata, mem_rdata;
  logic          cpu_ready, dev_ready, mem_req, mem_w, owner, bus_err;
  logic [DW-1:0] cpu_rdata, dev_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;

  int n_cmp = 0;
  int n_err = 0;

  mio_bus_arbiter #(
    .AW(AW), .DW(DW), .MAX_STREAK(4), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
    .dev_req(dev_req), .dev_we(dev_we), .dev_addr(dev_addr), .dev_wdata(dev_wdata),
    .dev_ready(dev_ready), .dev_rdata(dev_rdata),
    .mem_req(mem_req), .mem_w(mem_w), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One arbitrated transaction acked one cycle after grant, ending back in IDLE.
  task automatic xact(input string tag, input logic exp_own, input logic [31:0] rd);
    tick();
    chk({tag, " owner"}, 64'(owner), 64'(exp_own));
    chk({tag, " mem_req"}, 64'(mem_req), 64'd1);
    mem_rdata = rd;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk({tag, " ready"}, 64'({cpu_ready, dev_ready}), exp_own ? 64'b01 : 64'b10);
    chk({tag, " rdata"}, 64'(exp_own ? dev_rdata : cpu_rdata), 64'(rd));
    tick();
  endtask

  initial begin
    reset = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dev_req = 1'b0; dev_we = 1'b0; dev_addr = '0; dev_wdata = '0;
    mem_ack = 1'b0; mem_rdata = '0;
    tick();
    tick();
    chk("rst outputs", 64'({cpu_ready, dev_ready, mem_req, mem_w, owner, bus_err}), 64'd0);
    chk("rst data", 64'(cpu_rdata | dev_rdata | mem_wdata | mem_addr), 64'd0);
    reset = 1'b1;
    tick();

    // CPU-only read
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0010;
    tick();
    chk("cpu rd mem_req", 64'(mem_req), 64'd1);
    chk("cpu rd mem_addr", 64'(mem_addr), 64'h10);
    chk("cpu rd mem_w", 64'(mem_w), 64'd0);
    chk("cpu rd owner", 64'(owner), 64'd0);
    tick();
    chk("cpu rd busy hold", 64'({mem_req, cpu_ready}), 64'b10);
    mem_rdata = 32'h1234_5678;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    cpu_req = 1'b0;
    chk("cpu rd ready", 64'({cpu_ready, dev_ready, mem_req}), 64'b100);
    chk("cpu rd rdata", 64'(cpu_rdata), 64'h1234_5678);
    tick();
    chk("cpu rd ready pulse", 64'(cpu_ready), 64'd0);

    // dev write, request dropped while BUSY
    dev_req = 1'b1; dev_we = 1'b1; dev_addr = 32'h0000_0200; dev_wdata = 32'hA5A5_A5A5;
    tick();
    dev_req = 1'b0;
    chk("dev wr grant", 64'({mem_req, mem_w, owner}), 64'b111);
    chk("dev wr addr", 64'(mem_addr), 64'h200);
    chk("dev wr wdata", 64'(mem_wdata), 64'hA5A5_A5A5);
    tick();
    chk("dev wr hold", 64'({mem_req, mem_w, owner}), 64'b111);
    chk("dev wr hold data", 64'({mem_addr, mem_wdata}), {32'h200, 32'hA5A5_A5A5});
    mem_rdata = 32'hCAFE_0001;
    mem_ack   = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("dev wr ready", 64'({dev_ready, cpu_ready, mem_req, mem_w}), 64'b1000);
    chk("dev wr rdata", 64'(dev_rdata), 64'hCAFE_0001);
    chk("cpu rdata held", 64'(cpu_rdata), 64'h1234_5678);
    tick();
    chk("dev wr ready pulse", 64'(dev_ready), 64'd0);

    // Contested stream: CPU x4 then dev, then CPU
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h0000_0040;
    dev_req = 1'b1; dev_we = 1'b0; dev_addr = 32'h0000_0080;
    xact("arb0", 1'b0, 32'h0000_0A00);
    xact("arb1", 1'b0, 32'h0000_0A01);
    xact("arb2", 1'b0, 32'h0000_0A02);
    xact("arb3", 1'b0, 32'h0000_0A03);
    xact("arb4", 1'b1, 32'h0000_0A04);
    xact("arb5", 1'b0, 32'h0000_0A05);
    cpu_req = 1'b0;
    dev_req = 1'b0;

    // mem_ack in IDLE is ignored
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle ack ignored", 64'({cpu_ready, dev_ready, mem_req}), 64'd0);

    // Reset while BUSY
    cpu_req = 1'b1; cpu_addr = 32'h0000_0300;
    tick();
    chk("pre-reset busy", 64'(mem_req), 64'd1);
    reset = 1'b0;
    #1;
    chk("async reset mem_req", 64'({mem_req, cpu_ready}), 64'd0);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("reset no ready", 64'({cpu_ready, dev_ready, mem_req}), 64'd0);
    dev_req = 1'b1;
    reset = 1'b1;
    // Streak restarts at 0: four CPU wins before master 1
    xact("post0", 1'b0, 32'h0000_0B00);
    xact("post1", 1'b0, 32'h0000_0B01);
    xact("post2", 1'b0, 32'h0000_0B02);
    xact("post3", 1'b0, 32'h0000_0B03);
    xact("post4", 1'b1, 32'h0000_0B04);
    cpu_req = 1'b0;
    dev_req = 1'b0;
    tick();

`ifdef MIO_TIMEOUT_EN
    cpu_req = 1'b1; cpu_addr = 32'h0000_0500;
    tick();
    cpu_req = 1'b0;
    for (int i = 1; i < 8; i++) begin
      tick();
      chk($sformatf("tmo wait %0d", i), 64'({mem_req, cpu_ready, bus_err}), 64'b100);
    end
    tick();
    chk("tmo ready", 64'({cpu_ready, mem_req, bus_err}), 64'b101);
    chk("tmo rdata", 64'(cpu_rdata), 64'hDEAD_BEEF);
    tick();
    chk("tmo sticky", 64'({cpu_ready, bus_err}), 64'b01);
    cpu_req = 1'b1;
    xact("after tmo", 1'b0, 32'h0000_0C00);
    cpu_req = 1'b0;
    chk("bus_err held", 64'(bus_err), 64'd1);
`else
    chk("bus_err tied", 64'(bus_err), 64'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
